// File: rtl/alu_share_sequencer_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_share_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

endpackage

// File: rtl/alu_share_sequencer_rr_arbiter_2.sv
// Two-way combinational round-robin arbiter; ptr selects the winner on contention.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/alu_share_sequencer.sv
// Shares one external combinational ALU between requesters A and B, returning
// tagged results on a single response channel with per-requester completion counts.
module alu_share_sequencer
   import alu_share_sequencer_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int SEL_W  = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [SEL_W-1:0]  a_sel,
   input  logic [DATA_W-1:0] a_rs,
   input  logic [DATA_W-1:0] a_rt,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [SEL_W-1:0]  b_sel,
   input  logic [DATA_W-1:0] b_rs,
   input  logic [DATA_W-1:0] b_rt,
   output logic [SEL_W-1:0]  alu_sel,
   output logic [DATA_W-1:0] alu_rs,
   output logic [DATA_W-1:0] alu_rt,
   input  logic [DATA_W-1:0] alu_rd,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic [CNT_W-1:0]  a_done_cnt,
   output logic [CNT_W-1:0]  b_done_cnt
);

   state_t            state, state_nx;
   logic              rr_ptr;
   logic [1:0]        gnt;
   logic [SEL_W-1:0]  op_sel;
   logic [DATA_W-1:0] op_rs, op_rt;
   logic              op_id;

   rr_arbiter_2 u_arb (
      .req ({b_valid, a_valid}),
      .ptr (rr_ptr),
      .gnt (gnt)
   );

   assign alu_sel = op_sel;
   assign alu_rs  = op_rs;
   assign alu_rt  = op_rt;
   assign rsp_id  = op_id;

   // Readies are masked by rst_n so a held reset never shows a grant.
   always_comb begin
      state_nx  = state;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy    = 1'b0;
            a_ready = rst_n & gnt[0];
            b_ready = rst_n & gnt[1];
            if (|gnt) state_nx = EXEC;
         end
         EXEC: state_nx = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= 1'b0;
         op_sel     <= '0;
         op_rs      <= '0;
         op_rt      <= '0;
         op_id      <= ID_A;
         rsp_data   <= '0;
         a_done_cnt <= '0;
         b_done_cnt <= '0;
      end else begin
         if (a_ready || b_ready) begin
            op_sel <= gnt[1] ? b_sel : a_sel;
            op_rs  <= gnt[1] ? b_rs  : a_rs;
            op_rt  <= gnt[1] ? b_rt  : a_rt;
            op_id  <= gnt[1] ? ID_B  : ID_A;
         end
         if (state == EXEC) rsp_data <= alu_rd;
         if (state == RESP && rsp_ready) begin
            rr_ptr <= ~op_id;
            if (op_id == ID_B) b_done_cnt <= b_done_cnt + 1'b1;
            else               a_done_cnt <= a_done_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Randomised self-checking bench for alu_share_sequencer against a transaction-level model.
module tb_alu_share_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, b_valid, a_ready, b_ready;
   logic [2:0] a_sel, b_sel, alu_sel;
   logic [3:0] a_rs, a_rt, b_rs, b_rt, alu_rs, alu_rt, alu_rd, rsp_data;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] a_done_cnt, b_done_cnt;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // transaction-level model state
   logic       m_ptr;
   logic [7:0] m_a_cnt, m_b_cnt;

   // observations from the last do_op
   logic       g_a, g_b, x_vld, x_busy, x_rdy, r_vld, r_id, stable;
   logic [2:0] x_sel;
   logic [3:0] x_rs, x_rt, r_data;
   logic [7:0] c_a, c_b;

   alu_share_sequencer #(.DATA_W(4), .SEL_W(3), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_rs(a_rs), .a_rt(a_rt),
      .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_rs(b_rs), .b_rt(b_rt),
      .alu_sel(alu_sel), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_rd(alu_rd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy), .a_done_cnt(a_done_cnt), .b_done_cnt(b_done_cnt)
   );

   assign alu_rd = alu_rs + alu_rt;

   always #5 clk = ~clk;

   function automatic logic model_grant(input logic av, input logic bv);
      return (av && bv) ? m_ptr : bv;
   endfunction

   task automatic model_complete(input logic gid);
      m_ptr = ~gid;
      if (gid) m_b_cnt = m_b_cnt + 8'd1;
      else     m_a_cnt = m_a_cnt + 8'd1;
   endtask

   task automatic model_reset();
      m_ptr = 1'b0; m_a_cnt = '0; m_b_cnt = '0;
   endtask

   // one full transaction: offer in IDLE, observe EXEC, hold RESP for stall cycles, then accept
   task automatic do_op(input logic av, input logic [2:0] as, input logic [3:0] ars, input logic [3:0] art,
                        input logic bv, input logic [2:0] bs, input logic [3:0] brs, input logic [3:0] brt,
                        input int unsigned stall);
      @(negedge clk);
      a_valid = av; a_sel = as; a_rs = ars; a_rt = art;
      b_valid = bv; b_sel = bs; b_rs = brs; b_rt = brt;
      rsp_ready = 1'b0;
      #1; g_a = a_ready; g_b = b_ready;
      @(negedge clk);
      x_sel = alu_sel; x_rs = alu_rs; x_rt = alu_rt;
      x_vld = rsp_valid; x_busy = busy; x_rdy = a_ready | b_ready;
      a_sel = 3'($urandom); a_rs = 4'($urandom); a_rt = 4'($urandom);
      b_sel = 3'($urandom); b_rs = 4'($urandom); b_rt = 4'($urandom);
      @(negedge clk);
      r_vld = rsp_valid; r_id = rsp_id; r_data = rsp_data;
      c_a = a_done_cnt; c_b = b_done_cnt;
      stable = 1'b1;
      for (int unsigned i = 0; i < stall; i++) begin
         a_rs = 4'($urandom); b_rs = 4'($urandom);
         @(negedge clk);
         if (rsp_valid !== r_vld || rsp_id !== r_id || rsp_data !== r_data || a_ready || b_ready
             || busy !== 1'b1 || a_done_cnt !== c_a || b_done_cnt !== c_b || alu_rs !== x_rs)
            stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      c_a = a_done_cnt; c_b = b_done_cnt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
      a_sel = 3'd1; a_rs = 4'd1; a_rt = 4'd1; b_sel = 3'd2; b_rs = 4'd2; b_rt = 4'd2;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({a_ready, b_ready, rsp_valid, busy, rsp_id} !== 5'b0)
         $display("FAIL reset_ctrl: got a_rdy/b_rdy/vld/busy/id=%b required 00000",
                  {a_ready, b_ready, rsp_valid, busy, rsp_id});
      else n_pass++;
      n_checks++;
      if ({alu_sel, alu_rs, alu_rt, rsp_data} !== 15'b0)
         $display("FAIL reset_data: got alu_sel=%0d rs=%0d rt=%0d rsp_data=%0d required all 0",
                  alu_sel, alu_rs, alu_rt, rsp_data);
      else n_pass++;
      n_checks++;
      if (a_done_cnt !== 8'd0 || b_done_cnt !== 8'd0)
         $display("FAIL reset_cnt: got a=%0d b=%0d required 0 0", a_done_cnt, b_done_cnt);
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0)
         $display("FAIL reset_release_grant: got a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
      else n_pass++;
      a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      do_op(1'b1, 3'd2, 4'd3, 4'd5, 1'b0, 3'd0, 4'd0, 4'd0, 0);
      model_complete(1'b0);
      n_checks++;
      if (g_a !== 1'b1 || g_b !== 1'b0)
         $display("FAIL single_grant: got a_ready=%b b_ready=%b required 1 0", g_a, g_b);
      else n_pass++;
      n_checks++;
      if (x_sel !== 3'd2 || x_rs !== 4'd3 || x_rt !== 4'd5 || x_vld !== 1'b0 || x_busy !== 1'b1 || x_rdy !== 1'b0)
         $display("FAIL single_exec: got sel=%0d rs=%0d rt=%0d vld=%b busy=%b rdy=%b required 2 3 5 0 1 0",
                  x_sel, x_rs, x_rt, x_vld, x_busy, x_rdy);
      else n_pass++;
      n_checks++;
      if (r_vld !== 1'b1 || r_id !== 1'b0 || r_data !== 4'd8)
         $display("FAIL single_rsp: got vld=%b id=%b data=%0d required 1 0 8", r_vld, r_id, r_data);
      else n_pass++;
      n_checks++;
      if (c_a !== m_a_cnt || c_b !== m_b_cnt)
         $display("FAIL single_cnt: got a=%0d b=%0d required %0d %0d", c_a, c_b, m_a_cnt, m_b_cnt);
      else n_pass++;
   endtask

   task automatic test_contention();
      logic       gid;
      logic [3:0] ars, art, exp_d;
      // a B-only op first hands priority back to A
      do_op(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 3'd4, 4'd7, 4'd6, 0);
      model_complete(1'b1);
      n_checks++;
      if (g_b !== 1'b1 || r_id !== 1'b1 || r_data !== 4'd13 || c_b !== m_b_cnt)
         $display("FAIL b_only: got b_ready=%b id=%b data=%0d b_cnt=%0d required 1 1 13 %0d",
                  g_b, r_id, r_data, c_b, m_b_cnt);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         ars = 4'($urandom); art = 4'($urandom);
         gid = model_grant(1'b1, 1'b1);
         exp_d = gid ? 4'd2 : 4'(ars + art);
         do_op(1'b1, 3'd1, ars, art, 1'b1, 3'd5, 4'd9, 4'd9, 0);
         model_complete(gid);
         n_checks++;
         if ({g_b, g_a} !== (gid ? 2'b10 : 2'b01) || gid !== 1'(i % 2))
            $display("FAIL contention_grant[%0d]: got b_rdy,a_rdy=%b%b required id %0d", i, g_b, g_a, i % 2);
         else n_pass++;
         n_checks++;
         if (r_vld !== 1'b1 || r_id !== gid || r_data !== exp_d)
            $display("FAIL contention_rsp[%0d]: got vld=%b id=%b data=%0d required 1 %b %0d",
                     i, r_vld, r_id, r_data, gid, exp_d);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] pre_a, pre_b;
      pre_a = m_a_cnt; pre_b = m_b_cnt;
      do_op(1'b1, 3'd3, 4'd6, 4'd4, 1'b1, 3'd3, 4'd1, 4'd1, 5);
      n_checks++;
      if (stable !== 1'b1 || r_vld !== 1'b1 || r_id !== m_ptr || r_data !== (m_ptr ? 4'd2 : 4'd10))
         $display("FAIL backpressure_hold: got stable=%b vld=%b id=%b data=%0d", stable, r_vld, r_id, r_data);
      else n_pass++;
      n_checks++;
      if (x_rdy !== 1'b0)
         $display("FAIL backpressure_exec_ready: got %b required 0", x_rdy);
      else n_pass++;
      model_complete(m_ptr);
      n_checks++;
      if (c_a !== m_a_cnt || c_b !== m_b_cnt || (m_a_cnt + m_b_cnt) !== (pre_a + pre_b + 8'd1))
         $display("FAIL backpressure_cnt: got a=%0d b=%0d required %0d %0d", c_a, c_b, m_a_cnt, m_b_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      logic       av, bv, gid;
      logic [2:0] as, bs;
      logic [3:0] ars, art, brs, brt, exp_d;
      int unsigned errs;
      errs = 0;
      for (int i = 0; i < 30; i++) begin
         av = 1'($urandom); bv = 1'($urandom);
         if (!av && !bv) av = 1'b1;
         as = 3'($urandom); bs = 3'($urandom);
         ars = 4'($urandom); art = 4'($urandom); brs = 4'($urandom); brt = 4'($urandom);
         gid = model_grant(av, bv);
         exp_d = gid ? 4'(brs + brt) : 4'(ars + art);
         do_op(av, as, ars, art, bv, bs, brs, brt, $urandom_range(0, 2));
         model_complete(gid);
         if ({g_b, g_a} !== (gid ? 2'b10 : 2'b01) || x_sel !== (gid ? bs : as) || r_id !== gid
             || r_data !== exp_d || r_vld !== 1'b1 || !stable || c_a !== m_a_cnt || c_b !== m_b_cnt) begin
            errs++;
            if (errs < 4)
               $display("FAIL random_op[%0d]: got gnt=%b%b sel=%0d id=%b data=%0d cnt=%0d/%0d required id=%b data=%0d cnt=%0d/%0d",
                        i, g_b, g_a, x_sel, r_id, r_data, c_a, c_b, gid, exp_d, m_a_cnt, m_b_cnt);
         end
      end
      n_checks++;
      if (errs != 0) $display("FAIL random_summary: got %0d bad ops required 0", errs);
      else n_pass++;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      do_op(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 3'd0, 4'd1, 4'd2, 0);
      model_complete(1'b1);
      for (int i = 0; i < 255; i++) begin
         do_op(1'b1, 3'd0, 4'($urandom), 4'($urandom), 1'b0, 3'd0, 4'd0, 4'd0, 0);
         model_complete(1'b0);
      end
      n_checks++;
      if (c_a !== 8'd255 || c_b !== 8'd1)
         $display("FAIL wrap_pre: got a=%0d b=%0d required 255 1", c_a, c_b);
      else n_pass++;
      do_op(1'b1, 3'd0, 4'd1, 4'd1, 1'b0, 3'd0, 4'd0, 4'd0, 0);
      model_complete(1'b0);
      n_checks++;
      if (c_a !== 8'd0 || c_b !== 8'd1 || c_a !== m_a_cnt)
         $display("FAIL wrap: got a=%0d b=%0d required 0 1", c_a, c_b);
      else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic seen_vld;
      @(negedge clk);
      a_valid = 1'b1; a_sel = 3'd6; a_rs = 4'd2; a_rt = 4'd2; b_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0)
         $display("FAIL midop_exec: got busy=%b vld=%b required 1 0", busy, rsp_valid);
      else n_pass++;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || a_done_cnt !== 8'd0 || b_done_cnt !== 8'd0)
         $display("FAIL midop_reset: got busy=%b vld=%b a=%0d b=%0d required 0 0 0 0",
                  busy, rsp_valid, a_done_cnt, b_done_cnt);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      seen_vld = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) seen_vld = 1'b1;
      end
      n_checks++;
      if (seen_vld !== 1'b0 || a_done_cnt !== m_a_cnt || b_done_cnt !== m_b_cnt)
         $display("FAIL midop_discard: got late activity=%b a=%0d b=%0d required 0 0 0",
                  seen_vld, a_done_cnt, b_done_cnt);
      else n_pass++;
      rsp_ready = 1'b0;
      do_op(1'b1, 3'd1, 4'd4, 4'd4, 1'b1, 3'd1, 4'd1, 4'd1, 0);
      n_checks++;
      if (g_a !== 1'b1 || r_id !== 1'b0 || r_data !== 4'd8)
         $display("FAIL midop_ptr_reset: got a_ready=%b id=%b data=%0d required 1 0 8", g_a, r_id, r_data);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_random();
      test_wrap();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
